// File: rtl/bf_stage_ctrl.sv
`default_nettype none
// ==========================================================================
// bf_stage_ctrl : control sequencer for one radix-2 parallel butterfly stage
// Rev 1.0
// ==========================================================================
module bf_stage_ctrl #(
  parameter int NUM_BLK   = 32,
  parameter int PIPE_LAT  = 2,
  parameter int SEL_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 din_valid,
  input  logic                 err_clr,
  output logic                 in_sel,
  output logic                 out_sel,
  output logic [SEL_WIDTH-1:0] fac_sel,
  output logic                 dout_en,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err_gap,
  output logic                 err_overrun
);

  localparam int CNT_W = $clog2(NUM_BLK + PIPE_LAT + 2);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(NUM_BLK - 1);
  localparam logic [CNT_W-1:0] C_WIN_FIRST = CNT_W'(PIPE_LAT + 1);
  localparam logic [CNT_W-1:0] C_WIN_LAST  = CNT_W'(PIPE_LAT + NUM_BLK);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_in_win;

  // r_cnt is the cycle offset from beat 0; outputs are computed for the next cycle
  assign w_cnt_nxt = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + C_ONE;
  assign w_in_win  = (w_cnt_nxt >= C_WIN_FIRST) && (w_cnt_nxt <= C_WIN_LAST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      in_sel      <= 1'b0;
      out_sel     <= 1'b0;
      fac_sel     <= '0;
      dout_en     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      err_gap     <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_gap     <= err_gap & ~err_clr;
      err_overrun <= err_overrun & ~err_clr;
      frame_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          out_sel <= 1'b0;
          fac_sel <= '0;
          dout_en <= 1'b0;
          if (din_valid) begin
            r_state <= ST_FILL;
            r_cnt   <= w_cnt_nxt;
            in_sel  <= 1'b1;
            busy    <= 1'b1;
          end else begin
            r_cnt  <= '0;
            in_sel <= 1'b0;
            busy   <= 1'b0;
          end
        end
        ST_FILL, ST_DRAIN: begin
          if (r_state == ST_FILL && !din_valid) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            in_sel  <= 1'b0;
            out_sel <= 1'b0;
            fac_sel <= '0;
            dout_en <= 1'b0;
            busy    <= 1'b0;
            err_gap <= 1'b1;
          end else begin
            r_cnt   <= w_cnt_nxt;
            dout_en <= w_in_win;
            // output index j = next - first; j even selects the add path
            out_sel <= w_in_win & ~(w_cnt_nxt[0] ^ C_WIN_FIRST[0]);
            fac_sel <= w_in_win ? SEL_WIDTH'(w_cnt_nxt - C_WIN_FIRST) : '0;
            busy    <= (w_cnt_nxt <= C_WIN_LAST);
            if (r_state == ST_FILL) begin
              if (r_cnt == C_LAST_BEAT) begin
                r_state <= ST_DRAIN;
                in_sel  <= 1'b0;
              end else begin
                in_sel <= ~in_sel;
              end
            end else begin
              in_sel <= 1'b0;
              if (din_valid) err_overrun <= 1'b1;
              if (r_cnt == C_WIN_LAST) begin
                r_state    <= ST_IDLE;
                r_cnt      <= '0;
                frame_done <= 1'b1;
              end
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bf_stage_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_bf_stage_ctrl : randomized bench with a frame-timing reference model
// Rev 1.0
// ==========================================================================
module tb_bf_stage_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic din_valid = 1'b0;
  logic err_clr = 1'b0;

  logic       a_in_sel, a_out_sel, a_dout_en, a_busy, a_frame_done, a_err_gap, a_err_overrun;
  logic [1:0] a_fac_sel;
  logic       b_in_sel, b_out_sel, b_dout_en, b_busy, b_frame_done, b_err_gap, b_err_overrun;
  logic [0:0] b_fac_sel;

  always #5 clk = ~clk;

  bf_stage_ctrl #(.NUM_BLK(32), .PIPE_LAT(2), .SEL_WIDTH(2)) dut_a (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .err_clr(err_clr),
    .in_sel(a_in_sel), .out_sel(a_out_sel), .fac_sel(a_fac_sel), .dout_en(a_dout_en),
    .busy(a_busy), .frame_done(a_frame_done), .err_gap(a_err_gap), .err_overrun(a_err_overrun)
  );

  bf_stage_ctrl #(.NUM_BLK(4), .PIPE_LAT(1), .SEL_WIDTH(1)) dut_b (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .err_clr(err_clr),
    .in_sel(b_in_sel), .out_sel(b_out_sel), .fac_sel(b_fac_sel), .dout_en(b_dout_en),
    .busy(b_busy), .frame_done(b_frame_done), .err_gap(b_err_gap), .err_overrun(b_err_overrun)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  // Reference model: absolute start cycle of the current frame per instance
  int t0 [2];
  bit act [2];
  bit eg [2];
  bit eo [2];

  function automatic int nb(input int i);
    return (i == 0) ? 32 : 4;
  endfunction
  function automatic int pl(input int i);
    return (i == 0) ? 2 : 1;
  endfunction
  function automatic int sw(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge(input bit dv, input bit clr, input bit rn);
    int  k, n_, p_;
    bit  idle, fill, drain;
    for (int i = 0; i < 2; i++) begin
      n_ = nb(i);
      p_ = pl(i);
      if (!rn) begin
        act[i] = 1'b0;
        eg[i]  = 1'b0;
        eo[i]  = 1'b0;
      end else begin
        k     = cyc - t0[i];
        idle  = !act[i] || (k > p_ + n_);
        fill  = !idle && (k <= n_ - 1);
        drain = !idle && (k >= n_);
        eg[i] = (fill && !dv) || (eg[i] && !clr);
        eo[i] = (drain && dv) || (eo[i] && !clr);
        if (idle && dv) begin
          act[i] = 1'b1;
          t0[i]  = cyc;
        end else if (fill && !dv) begin
          act[i] = 1'b0;
        end
      end
    end
    cyc++;
  endtask

  task automatic check_inst(input int i, input logic is_, input logic os_, input logic [1:0] fs_,
                            input logic de_, input logic bz_, input logic fd_,
                            input logic eg_, input logic eo_);
    int k, j, n_, p_;
    bit x_is, x_os, x_de, x_bz, x_fd;
    int x_fs;
    n_ = nb(i);
    p_ = pl(i);
    k  = cyc - t0[i];
    j  = k - p_ - 1;
    x_is = 0; x_os = 0; x_de = 0; x_bz = 0; x_fd = 0; x_fs = 0;
    if (act[i]) begin
      x_bz = (k >= 1) && (k <= p_ + n_);
      x_de = (k >= p_ + 1) && (k <= p_ + n_);
      x_is = (k >= 1) && (k <= n_ - 1) && (k % 2 == 1);
      x_os = x_de && (j % 2 == 0);
      x_fs = x_de ? (j % (1 << sw(i))) : 0;
      x_fd = (k == p_ + n_ + 1);
    end
    chk($sformatf("in_sel%0d", i),      32'(is_), 32'(x_is));
    chk($sformatf("out_sel%0d", i),     32'(os_), 32'(x_os));
    chk($sformatf("fac_sel%0d", i),     32'(fs_), 32'(x_fs));
    chk($sformatf("dout_en%0d", i),     32'(de_), 32'(x_de));
    chk($sformatf("busy%0d", i),        32'(bz_), 32'(x_bz));
    chk($sformatf("frame_done%0d", i),  32'(fd_), 32'(x_fd));
    chk($sformatf("err_gap%0d", i),     32'(eg_), 32'(eg[i]));
    chk($sformatf("err_overrun%0d", i), 32'(eo_), 32'(eo[i]));
  endtask

  task automatic step(input bit dv, input bit clr, input bit rn);
    din_valid = dv;
    err_clr   = clr;
    rstn      = rn;
    @(posedge clk);
    model_edge(dv, clr, rn);
    #1;
    check_inst(0, a_in_sel, a_out_sel, a_fac_sel, a_dout_en, a_busy, a_frame_done,
               a_err_gap, a_err_overrun);
    check_inst(1, b_in_sel, b_out_sel, {1'b0, b_fac_sel}, b_dout_en, b_busy, b_frame_done,
               b_err_gap, b_err_overrun);
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int r;
    for (int i = 0; i < 2; i++) begin
      t0[i] = 0; act[i] = 0; eg[i] = 0; eo[i] = 0;
    end
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // single frame, then two frames back-to-back (beat 0 in the done cycle)
    beats(32); idle(5);
    beats(32); idle(3); beats(32); idle(6);

    // gap at T0+10, clear, fresh frame
    beats(10); idle(3); step(1'b0, 1'b1, 1'b1); idle(2);
    beats(32); idle(5);

    // overrun pulse at T0+33, then overrun coinciding with err_clr
    beats(32); idle(1); step(1'b1, 1'b0, 1'b1); idle(4);
    step(1'b0, 1'b1, 1'b1);
    beats(32); idle(1); step(1'b1, 1'b1, 1'b1); idle(4);
    step(1'b0, 1'b1, 1'b1); idle(2);

    // reset mid-frame, then a clean frame
    beats(20); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    beats(32); idle(5);

    // randomized segments
    for (int s = 0; s < 70; s++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5) begin
        beats(32); idle(int'($urandom_range(0, 5)));
      end else if (r < 7) begin
        beats(int'($urandom_range(1, 40))); idle(int'($urandom_range(0, 4)));
      end else if (r == 7) begin
        for (int c = 0; c < 12; c++)
          step(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 1'b1);
      end else if (r == 8) begin
        step(1'b0, 1'b1, 1'b1);
      end else begin
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
    end
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bf_stage_ctrl.md
Name: bf_stage_ctrl

Overview:
- Control sequencer for one radix-2 parallel butterfly stage (demux, delay, add/sub, output mux, twiddle multiplier).
- Accepts a contiguous frame of NUM_BLK input beats on din_valid.
- Drives the stage's input demux select, output mux select, twiddle-factor select and output-enable with the correct pipeline alignment.
- Also detects framing errors (mid-frame gaps, input during drain) and reports frame completion.

Parameters:
- NUM_BLK, 32: input beats per frame (16-lane vectors per beat); must be even, >=2.
- PIPE_LAT, 2: cycles from sampling beat 0 to the cycle before the first output beat; >=1.
- SEL_WIDTH, 2: width of fac_sel.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, synchronous, active-low.
- din_valid  in  1  input beat present this cycle.
- err_clr  in  1  clears sticky error flags.
- in_sel  out  1  demux select: 0 = route to delay line, 1 = route to add/sub.
- out_sel  out  1  output mux select: 1 = add path, 0 = delayed sub path.
- fac_sel  out  SEL_WIDTH  twiddle select for the multiplier.
- dout_en  out  1  stage output valid.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last output beat.
- err_gap  out  1  sticky: din_valid dropped mid-frame.
- err_overrun  out  1  sticky: din_valid seen while draining.

Behaviour:
- Reset and outputs:
  - One clock; reset is synchronous and active-low.
  - rstn low at any edge, including mid-frame: all outputs 0 and state IDLE after that edge. Errors are also cleared.
  - All outputs are registered.
- States: IDLE, FILL, DRAIN.
- Timing reference: T0 is the cycle in which din_valid=1 is sampled in IDLE (beat 0). Beat k is sampled in cycle T0+k.
- IDLE: din_valid=1 accepts beat 0, then FILL. din_valid=0 keeps IDLE.
- FILL:
  - Expects din_valid=1 in every cycle T0+1 .. T0+NUM_BLK-1.
  - After beat NUM_BLK-1 is sampled, go to DRAIN.
- Gap in FILL (din_valid=0): err_gap set, abort to IDLE, all outputs 0 next cycle, no frame_done.
- in_sel:
  - 0 in IDLE; toggles after every accepted beat, so in_sel during beat k equals k[0].
  - Forced to 0 once the last beat is sampled, and on abort.
- Output window:
  - dout_en is high exactly in cycles T0+PIPE_LAT+1 .. T0+PIPE_LAT+NUM_BLK, independent of state FILL/DRAIN.
  - out_sel in output cycle j (j=0..NUM_BLK-1) is ~j[0]: 1 on the first output cycle.
  - fac_sel in output cycle j is j mod 2^SEL_WIDTH.
  - Outside the window, out_sel=0 and fac_sel=0.
- busy: high in cycles T0+1 .. T0+PIPE_LAT+NUM_BLK.
- Frame completion:
  - In cycle T0+PIPE_LAT+NUM_BLK+1: frame_done=1, busy=0, dout_en=0, state IDLE.
  - din_valid in that cycle is accepted as beat 0 of the next frame (back-to-back, no bubble).
- DRAIN: din_valid=1 sets err_overrun; the beat is ignored and does not start a frame.
- Error flags: err_clr clears both flags next edge. A simultaneous new error event wins (flag stays 1).
- Counters:
  - Single cycle counter of width $clog2(NUM_BLK+PIPE_LAT+2).
  - Must not wrap within a frame; saturates and is cleared on return to IDLE.

Test Plan:
- Reset, then 32 contiguous beats from T0, defaults:
  - in_sel toggles 0,1,0,… during beats.
  - dout_en high T0+3..T0+34.
  - out_sel 1,0,1,… starting T0+3.
  - fac_sel 0,1,2,3,0,… starting T0+3.
  - frame_done and busy=0 at T0+35.
- Two frames back-to-back, second beat 0 in the frame_done cycle: second window at T0'+3..T0'+34, no lost beat, no errors.
- din_valid low at T0+10: err_gap=1 next cycle; dout_en, busy and in_sel 0; no frame_done.
  - err_clr then clears err_gap.
  - A new frame then runs normally.
- din_valid pulse at T0+33 (DRAIN): err_overrun=1; output window unchanged; no extra frame.
- err_clr asserted in the same cycle as an overrun: err_overrun remains 1.
- rstn low at T0+20, released two cycles later: all outputs 0 from the next edge; a fresh frame then produces correct timing.
- Parameter sweep NUM_BLK=4, PIPE_LAT=1, SEL_WIDTH=1:
  - dout_en high T0+2..T0+5.
  - fac_sel 0,1,0,1.
  - frame_done at T0+6.
